// File: rtl/fft_ctrl_param.sv
// Address, bank-rotation and twiddle-exponent sequencer for a radix-4 memory-based FFT.
// Optional macro FFT_CTRL_INV_EN adds the INV port and negated (inverse-transform) exponents.
module fft_ctrl_param #(
  parameter int D   = 3,
  parameter int LAT = 4,
  localparam int AW = 2*D,
  localparam int EW = 2*D+2
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            START,
  input  logic            ABORT,
`ifdef FFT_CTRL_INV_EN
  input  logic            INV,
`endif
  output logic            BUSY,
  output logic            DONE,
  output logic            SEL_EXTN,
  output logic            SEL_ITR,
  output logic [1:0]      SEL_PERMW,
  output logic [1:0]      SEL_PERMR,
  output logic [1:0]      SEL_ROT,
  output logic            WE_IOBUF,
  output logic            WE_FSC,
  output logic [4*AW-1:0] ADDR_IOBUF,
  output logic [4*AW-1:0] ADDR_FSC,
  output logic [4*EW-1:0] EXP
);

  typedef enum logic [2:0] {IDLE, INPT, ITR1, ITR2, OUPT, DRN} state_t;

  localparam logic [AW-1:0] W_TRIG = AW'(LAT-1);
  localparam logic [AW-1:0] E_TRIG = AW'(LAT-2);

  state_t        state;
  logic [AW-1:0] cnt, w, e;
  logic          w_act, e_act;
  logic [1:0]    drn;
  logic [1:0]    permr_p1;
  logic [1:0]    rot_c, rot_w;
`ifdef FFT_CTRL_INV_EN
  logic          inv_q;
`endif

  function automatic logic [1:0] rot(input logic [AW-1:0] x);
    logic [1:0] s;
    s = 2'd0;
    for (int i = 0; i < D; i++) s = s + x[2*i +: 2];
    return s;
  endfunction

  function automatic logic [AW-1:0] addr_itr1(input logic [AW-1:0] x, input logic [1:0] a);
    return {a, x[1:0], x[AW-1:4]};
  endfunction

  function automatic logic [AW-1:0] addr_itr2(input logic [AW-1:0] x, input logic [1:0] a);
    return {x[AW-1:2], a};
  endfunction

  function automatic logic [AW-1:0] addr_oupt(input logic [AW-1:0] x, input logic [1:0] a);
    return {x[1:0], a, x[AW-1:4]};
  endfunction

  function automatic logic [EW-1:0] exp_of(input logic [AW-1:0] x, input logic [1:0] b);
    logic [EW-1:0] n, m;
    n = EW'(x[AW-1:2]);
    m = EW'({b, x[1:0]});
    return n * m;
  endfunction

  assign rot_c = rot(cnt);
  assign rot_w = rot(w);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      cnt      <= '0;
      w        <= '0;
      e        <= '0;
      w_act    <= 1'b0;
      e_act    <= 1'b0;
      drn      <= '0;
      permr_p1 <= '0;
`ifdef FFT_CTRL_INV_EN
      inv_q    <= 1'b0;
`endif
    end else if (ABORT && state != IDLE) begin
      state    <= IDLE;
      cnt      <= '0;
      w        <= '0;
      e        <= '0;
      w_act    <= 1'b0;
      e_act    <= 1'b0;
      drn      <= '0;
      permr_p1 <= '0;
`ifdef FFT_CTRL_INV_EN
      inv_q    <= 1'b0;
`endif
    end else begin
      permr_p1 <= rot_c;
      case (state)
        IDLE: if (START) begin
          state <= INPT;
`ifdef FFT_CTRL_INV_EN
          inv_q <= INV;
`endif
        end
        INPT, OUPT: if (&cnt) begin
          cnt   <= '0;
          state <= (state == INPT) ? ITR1 : DRN;
        end else begin
          cnt <= cnt + AW'(1);
        end
        // W and E trail CNT by LAT and LAT-1 and keep running after CNT wraps
        ITR1, ITR2: if (&w) begin
          cnt   <= '0;
          w     <= '0;
          e     <= '0;
          w_act <= 1'b0;
          e_act <= 1'b0;
          state <= (state == ITR1) ? ITR2 : OUPT;
        end else begin
          cnt   <= cnt + AW'(1);
          w_act <= w_act | (cnt == W_TRIG);
          e_act <= e_act | (cnt == E_TRIG);
          if (w_act) w <= w + AW'(1);
          if (e_act) e <= e + AW'(1);
        end
        DRN: if (drn == 2'd2) begin
          drn   <= '0;
          state <= IDLE;
        end else begin
          drn <= drn + 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    BUSY       = (state != IDLE);
    DONE       = (state == OUPT);
    SEL_EXTN   = (state != INPT);
    SEL_ITR    = (state == ITR2);
    SEL_PERMW  = (state == INPT) ? rot_c : rot_w;
    SEL_PERMR  = permr_p1;
    SEL_ROT    = (state == ITR1 || state == ITR2) ? (cnt[1:0] - 2'd1) : 2'd0;
    WE_IOBUF   = (state == INPT || state == ITR2);
    WE_FSC     = (state == ITR1);
    ADDR_IOBUF = '0;
    ADDR_FSC   = '0;
    EXP        = '0;
    for (int b = 0; b < 4; b++) begin
      case (state)
        INPT: ADDR_IOBUF[b*AW +: AW] = cnt;
        ITR1: begin
          ADDR_IOBUF[b*AW +: AW] = addr_itr1(cnt, 2'(b) - rot_c);
          ADDR_FSC[b*AW +: AW]   = addr_itr1(w, 2'(b) - rot_w);
`ifdef FFT_CTRL_INV_EN
          EXP[b*EW +: EW] = inv_q ? (EW'(0) - exp_of(e, 2'(b))) : exp_of(e, 2'(b));
`else
          EXP[b*EW +: EW] = exp_of(e, 2'(b));
`endif
        end
        ITR2: begin
          ADDR_FSC[b*AW +: AW]   = addr_itr2(cnt, 2'(b) - rot_c);
          ADDR_IOBUF[b*AW +: AW] = addr_itr2(w, 2'(b) - rot_w);
        end
        OUPT: ADDR_IOBUF[b*AW +: AW] = addr_oupt(cnt, 2'(b) - rot_c);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_ctrl_param.sv
// Randomised bench for fft_ctrl_param against a phase/duration reference model.
module tb_fft_ctrl_param;

  localparam int D      = 3;
  localparam int LAT    = 4;
  localparam int AW     = 2*D;
  localparam int EW     = 2*D+2;
  localparam int N      = 4**D;
  localparam int P1     = 4**(D-1);
  localparam int P2     = 4**(D-2);
  localparam int EW_MOD = 2**EW;
  localparam int VW     = 12 + 8*AW + 4*EW;
  localparam int TOTAL  = N + 2*(N+LAT) + N + 3;
`ifdef FFT_CTRL_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_INPT = 1, P_ITR1 = 2, P_ITR2 = 3, P_OUPT = 4, P_DRN = 5;

  logic CLK = 1'b0;
  logic RSTn = 1'b1;
  logic START = 1'b0;
  logic ABORT = 1'b0;
`ifdef FFT_CTRL_INV_EN
  logic INV = 1'b0;
`endif
  logic            BUSY, DONE, SEL_EXTN, SEL_ITR, WE_IOBUF, WE_FSC;
  logic [1:0]      SEL_PERMW, SEL_PERMR, SEL_ROT;
  logic [4*AW-1:0] ADDR_IOBUF, ADDR_FSC;
  logic [4*EW-1:0] EXP;

  fft_ctrl_param #(.D(D), .LAT(LAT)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START), .ABORT(ABORT),
`ifdef FFT_CTRL_INV_EN
    .INV(INV),
`endif
    .BUSY(BUSY), .DONE(DONE), .SEL_EXTN(SEL_EXTN), .SEL_ITR(SEL_ITR),
    .SEL_PERMW(SEL_PERMW), .SEL_PERMR(SEL_PERMR), .SEL_ROT(SEL_ROT),
    .WE_IOBUF(WE_IOBUF), .WE_FSC(WE_FSC),
    .ADDR_IOBUF(ADDR_IOBUF), .ADDR_FSC(ADDR_FSC), .EXP(EXP)
  );

  always #5 CLK = ~CLK;

  logic [VW-1:0] act_vec, exp_vec;
  assign act_vec = {BUSY, DONE, SEL_EXTN, SEL_ITR, SEL_PERMW, SEL_PERMR, SEL_ROT,
                    WE_IOBUF, WE_FSC, ADDR_IOBUF, ADDR_FSC, EXP};

  int checks = 0;
  int errors = 0;
  int m_ph = P_IDLE, m_k = 0, m_permr = 0;
  bit m_inv = 1'b0;

  function automatic int rot(int x);
    int s = 0;
    for (int i = 0; i < D; i++) s += (x / (4**i)) % 4;
    return s % 4;
  endfunction

  function automatic int len_of(int ph);
    case (ph)
      P_INPT, P_OUPT: return N;
      P_ITR1, P_ITR2: return N + LAT;
      default:        return 3;
    endcase
  endfunction

  function automatic int cnt_of(int ph, int k);
    if (ph == P_INPT || ph == P_OUPT) return k;
    if (ph == P_ITR1 || ph == P_ITR2) return k % N;
    return 0;
  endfunction

  function automatic logic [VW-1:0] model_vec(int ph, int k, bit inv, int permr);
    int c, w, e, rc, rw, ac, aw, v;
    bit itr;
    logic [4*AW-1:0] io, fs;
    logic [4*EW-1:0] ex;
    logic [1:0] pw, sr;
    itr = (ph == P_ITR1 || ph == P_ITR2);
    c  = cnt_of(ph, k);
    w  = (itr && k >= LAT)   ? (k - LAT) % N     : 0;
    e  = (itr && k >= LAT-1) ? (k - LAT + 1) % N : 0;
    rc = rot(c);
    rw = rot(w);
    io = '0; fs = '0; ex = '0;
    for (int b = 0; b < 4; b++) begin
      ac = (b + 4 - rc) % 4;
      aw = (b + 4 - rw) % 4;
      case (ph)
        P_INPT: io[b*AW +: AW] = AW'(c);
        P_ITR1: begin
          io[b*AW +: AW] = AW'(ac*P1 + (c%4)*P2 + c/16);
          fs[b*AW +: AW] = AW'(aw*P1 + (w%4)*P2 + w/16);
          v = ((e/4) * (e%4 + 4*b)) % EW_MOD;
          if (inv) v = (EW_MOD - v) % EW_MOD;
          ex[b*EW +: EW] = EW'(v);
        end
        P_ITR2: begin
          fs[b*AW +: AW] = AW'((c/4)*4 + ac);
          io[b*AW +: AW] = AW'((w/4)*4 + aw);
        end
        P_OUPT: io[b*AW +: AW] = AW'((c%4)*P1 + ac*P2 + c/16);
        default: ;
      endcase
    end
    pw = 2'((ph == P_INPT) ? rc : rw);
    sr = itr ? 2'((c%4 + 3) % 4) : 2'd0;
    return {ph != P_IDLE, ph == P_OUPT, ph != P_INPT, ph == P_ITR2, pw, 2'(permr), sr,
            (ph == P_INPT || ph == P_ITR2), ph == P_ITR1, io, fs, ex};
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_k = 0; m_permr = 0; m_inv = 1'b0;
    exp_vec = model_vec(m_ph, m_k, m_inv, m_permr);
  endtask

  // Drive one cycle of inputs (called at the falling edge), advance the model, return at the next falling edge.
  task automatic step(input bit st, input bit ab, input bit iv);
    int c;
    START = st;
    ABORT = ab;
`ifdef FFT_CTRL_INV_EN
    INV = iv;
`endif
    c = cnt_of(m_ph, m_k);
    if (ab && m_ph != P_IDLE) begin
      m_ph = P_IDLE; m_k = 0; m_permr = 0; m_inv = 1'b0;
    end else begin
      m_permr = rot(c);
      if (m_ph == P_IDLE) begin
        if (st) begin m_ph = P_INPT; m_k = 0; m_inv = INV_EN && iv; end
      end else begin
        m_k++;
        if (m_k == len_of(m_ph)) begin
          m_ph = (m_ph == P_DRN) ? P_IDLE : m_ph + 1;
          m_k = 0;
        end
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    exp_vec = model_vec(m_ph, m_k, m_inv, m_permr);
  endtask

  task automatic test_reset();
    #2 RSTn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_vec !== exp_vec) begin
      errors++; $display("FAIL reset_async got=%h exp=%h", act_vec, exp_vec);
    end
    @(negedge CLK);
    checks++;
    if (act_vec !== exp_vec || SEL_EXTN !== 1'b1 || BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_held got=%h exp=%h", act_vec, exp_vec);
    end
    RSTn = 1'b1;
  endtask

  task automatic test_full_transform(input bit iv);
    int busy_n = 0, done_n = 0;
    logic [4*AW-1:0] want_a;
    logic [4*EW-1:0] want_e;
    want_a = {6'd20, 6'd4, 6'd52, 6'd36};
    step(1'b1, 1'b0, iv);
    while (m_ph != P_IDLE) begin
      checks++;
      if (act_vec !== exp_vec) begin
        errors++; $display("FAIL full ph=%0d k=%0d got=%h exp=%h", m_ph, m_k, act_vec, exp_vec);
      end
      busy_n += int'(BUSY);
      done_n += int'(DONE);
      if (m_ph == P_ITR1 && m_k == 5) begin
        checks++;
        if (ADDR_IOBUF !== want_a) begin
          errors++; $display("FAIL itr1_cnt5_addr got=%h exp=%h", ADDR_IOBUF, want_a);
        end
      end
      if (m_ph == P_ITR1 && m_k == LAT - 1 + 6) begin
        want_e = m_inv ? {8'd242, 8'd246, 8'd250, 8'd254} : {8'd14, 8'd10, 8'd6, 8'd2};
        checks++;
        if (EXP !== want_e) begin
          errors++; $display("FAIL itr1_e6_exp got=%h exp=%h", EXP, want_e);
        end
      end
      step(1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (busy_n !== TOTAL) begin
      errors++; $display("FAIL busy_len got=%0d exp=%0d", busy_n, TOTAL);
    end
    checks++;
    if (done_n !== N) begin
      errors++; $display("FAIL done_len got=%0d exp=%0d", done_n, N);
    end
    checks++;
    if (act_vec !== exp_vec) begin
      errors++; $display("FAIL full_end_idle got=%h exp=%h", act_vec, exp_vec);
    end
  endtask

  task automatic test_abort();
    step(1'b1, 1'b0, 1'b0);
    while (!(m_ph == P_ITR2 && m_k == 10)) begin
      checks++;
      if (act_vec !== exp_vec) begin
        errors++; $display("FAIL abort_run ph=%0d k=%0d got=%h exp=%h", m_ph, m_k, act_vec, exp_vec);
      end
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (BUSY !== 1'b0 || WE_IOBUF !== 1'b0 || WE_FSC !== 1'b0 || act_vec !== exp_vec) begin
      errors++; $display("FAIL abort_itr2 got=%h exp=%h", act_vec, exp_vec);
    end
  endtask

  task automatic test_abort_idle();
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (act_vec !== exp_vec) begin
      errors++; $display("FAIL abort_idle got=%h exp=%h", act_vec, exp_vec);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (BUSY !== 1'b1 || act_vec !== exp_vec) begin
      errors++; $display("FAIL start_with_abort_idle got=%h exp=%h", act_vec, exp_vec);
    end
    step(1'b1, 1'b1, 1'b0);
    checks++;
    if (BUSY !== 1'b0 || act_vec !== exp_vec) begin
      errors++; $display("FAIL abort_inpt got=%h exp=%h", act_vec, exp_vec);
    end
  endtask

  task automatic test_async_reset();
    int stop_k;
    stop_k = $urandom_range(N-1, 0);
    step(1'b1, 1'b0, 1'b1);
    while (!(m_ph == P_OUPT && m_k == stop_k)) begin
      checks++;
      if (act_vec !== exp_vec) begin
        errors++; $display("FAIL rst_run ph=%0d k=%0d got=%h exp=%h", m_ph, m_k, act_vec, exp_vec);
      end
      step(1'b0, 1'b0, 1'b0);
    end
    #2 RSTn = 1'b0;
    model_reset();
    #1;
    checks++;
    if (act_vec !== exp_vec) begin
      errors++; $display("FAIL rst_oupt_async got=%h exp=%h", act_vec, exp_vec);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (BUSY !== 1'b1 || act_vec !== exp_vec) begin
      errors++; $display("FAIL start_after_release got=%h exp=%h", act_vec, exp_vec);
    end
    while (m_ph != P_IDLE) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    bit st, ab, iv;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      checks++;
      if (act_vec !== exp_vec) begin
        errors++; $display("FAIL random ph=%0d k=%0d got=%h exp=%h", m_ph, m_k, act_vec, exp_vec);
      end
      st = (m_ph == P_IDLE) ? ($urandom_range(3, 0) == 0) : ($urandom_range(7, 0) == 0);
      ab = ($urandom_range(799, 0) == 0);
      iv = 1'($urandom_range(1, 0));
      step(st, ab, iv);
    end
  endtask

  task automatic test_back_to_back();
    test_full_transform(1'b1);
    test_full_transform(1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    @(negedge CLK);
    test_full_transform(1'b0);
    test_abort();
    test_full_transform(1'b1);
    test_abort_idle();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_ctrl_param.md
FFT_CTRL_PARAM -- requirements
Module: fft_ctrl_param

Interface
REQ-001 SHALL have parameter D, default 3, meaning base-4 address digits per bank; bank depth is 4^D, transform size is 4^(D+1); legal range 3..6.
REQ-002 SHALL have parameter LAT, default 4, meaning datapath latency from read address to write address; legal range 2..8.
REQ-003 SHALL have local parameters AW = 2*D (address width) and EW = 2*D+2 (exponent width).
REQ-004 CLK  in  1  single clock; all state changes on the rising edge.
REQ-005 RSTn  in  1  asynchronous active-low reset.
REQ-006 START  in  1  begin a transform; honoured only in IDLE.
REQ-007 ABORT  in  1  synchronous abort; returns the block to IDLE.
REQ-008 INV  in  1  inverse-transform request, sampled with START (present only with FFT_CTRL_INV_EN).
REQ-009 BUSY  out  1  high in every state except IDLE.
REQ-010 DONE  out  1  high throughout OUPT.
REQ-011 SEL_EXTN / SEL_ITR  out  1/1  SEL_EXTN is 0 in INPT, else 1; SEL_ITR is 1 in ITR2 only.
REQ-012 SEL_PERMW / SEL_PERMR  out  2/2  write / read bank rotation.
REQ-013 SEL_ROT  out  2  rotator and 4x4 unit select = (C[0]-1) mod 4 in ITR1/ITR2, else 0.
REQ-014 WE_IOBUF / WE_FSC  out  1/1  WE_IOBUF is 1 in INPT and ITR2; WE_FSC is 1 in ITR1.
REQ-015 ADDR_IOBUF / ADDR_FSC  out  4*AW each  per-bank addresses; bank b occupies bits [b*AW +: AW].
REQ-016 EXP  out  4*EW  per-bank twiddle exponents; bank b occupies bits [b*EW +: EW].

Function
REQ-017 SHALL implement the states IDLE, INPT, ITR1, ITR2, OUPT, DRN (drain).
- Transitions: IDLE->INPT on START; INPT->ITR1 when CNT is all ones; ITR1->ITR2 and ITR2->OUPT when W is all ones; OUPT->DRN when CNT is all ones; DRN->IDLE after 3 cycles.
REQ-018 The CNT counter (AW bits) SHALL be 0 on state entry, increment each cycle in INPT/ITR1/ITR2/OUPT, and clear on every state exit.
REQ-019 The write counter W (AW bits) SHALL hold 0 until CNT >= LAT in ITR1/ITR2, then equal CNT-LAT, continuing past CNT wrap; each ITR state lasts 4^D+LAT cycles.
REQ-020 The exponent counter E SHALL follow the same rule as W with lag LAT-1.
REQ-021 C[i], W[i] and E[i] SHALL denote 2-bit digit i, with digit 0 the LSB.
- Bank rotation: R(x) = sum of the digits of x, mod 4.
- A_x[b] = (b - R(x)) mod 4.
REQ-022 SEL_PERMW SHALL be R(CNT) in INPT and R(W) otherwise.
- SEL_PERMR SHALL be R(CNT) registered once.
REQ-023 The read address, written as MSB..LSB digit concatenation, SHALL be:
- ITR1: {A_CNT[b], C[0], C[D-1..2]} on the IOBUF port.
- ITR2: {C[D-1..1], A_CNT[b]} on the FSC port.
REQ-024 The write address SHALL be:
- ITR1: {A_W[b], W[0], W[D-1..2]} on the FSC port.
- ITR2: {W[D-1..1], A_W[b]} on the IOBUF port.
REQ-025 The IOBUF address SHALL be CNT in INPT and {C[0], A_CNT[b], C[D-1..2]} in OUPT.
- All address outputs not driven by REQ-023..025 SHALL be 0.
REQ-026 EXP[b] SHALL be n*(E[0]+4b) mod 2^EW in ITR1, where n = value of E[D-1..1], and 0 in all other states.
REQ-027 Simultaneous events:
- START outside IDLE is ignored.
- ABORT has priority over all transitions, forces IDLE and clears all counters on the next edge.
- ABORT in IDLE has no effect.
REQ-028 All outputs SHALL be combinational decodes of registered state and counters; there SHALL be no combinational path from START, ABORT or INV to any output.

Reset
REQ-029 On RSTn low: STATE=IDLE; CNT, W, E, registered rotation and inverse flag all 0; BUSY=DONE=0, SEL_EXTN=1, every WE, address and EXP output 0.
REQ-030 Reset asserted mid-transform SHALL take effect immediately, without waiting for a clock edge.
REQ-031 Release SHALL be synchronised externally; the block needs no cycle after release before accepting START.

Configuration
REQ-032 With macro FFT_CTRL_INV_EN defined: INV port present, latched on an accepted START, and while latched each EXP[b] SHALL be (2^EW - value) mod 2^EW.
REQ-033 Without FFT_CTRL_INV_EN: no INV port, and EXP SHALL be exactly per REQ-026.

Verification
REQ-034 Defaults, START for one cycle, full transform -> BUSY high for exactly 64+68+68+64+3 = 267 cycles; DONE high for 64 cycles.
REQ-035 ITR1, CNT=5 (digits 0,1,1) -> ADDR_IOBUF banks 0..3 = {2,1,0}, {3,1,0}, {0,1,0}, {1,1,0}, i.e. 36, 52, 4, 20.
REQ-036 ITR1 with E=6 (n=1, E[0]=2) -> EXP = 2, 6, 10, 14.
- With FFT_CTRL_INV_EN and INV=1 -> EXP = 254, 250, 246, 242.
REQ-037 ABORT in ITR2 at CNT=10 -> next cycle STATE=IDLE, BUSY=0, all WE=0; a following START runs a full 267-cycle transform.
REQ-038 RSTn pulsed low in OUPT -> all outputs at reset values before the next CLK edge.
REQ-039 D=4, LAT=6 -> INPT lasts 256 cycles, each ITR lasts 262 cycles, EW=10, first FSC write at ITR1 cycle 6.
